// File: rtl/amp_cfg_seq.sv
// Power-up and configuration sequencer for the class-D amplifier: enable, power-up wait,
// init-table replay over a write-only I2C master, then host write arbitration and mute control.
module amp_cfg_seq #(
  parameter int unsigned CLK_DIV   = 60,
  parameter logic [6:0]  DEV_ADDR  = 7'h20,
  parameter int unsigned PWRUP_CYC = 1000,
  parameter int unsigned N_INIT    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mute,
  input  logic       host_req,
  input  logic [7:0] host_reg,
  input  logic [7:0] host_val,
  output logic       host_ack,
  output logic       host_nack,
  output logic [3:0] tbl_idx,
  input  logic [7:0] tbl_reg,
  input  logic [7:0] tbl_val,
  output logic       scl,
  input  logic       sdai,
  output logic       sdao,
  output logic       amp_nenable,
  output logic       amp_nmute,
  output logic       busy,
  output logic       done,
  output logic       nack_err
);

  localparam int unsigned QW = $clog2(CLK_DIV);
  localparam int unsigned WW = $clog2(PWRUP_CYC + 1);

  typedef enum logic [2:0] {StIdle, StPwrup, StInit, StDone, StErr} st_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxBit, TxStop} tx_e;

  st_e          st_q, st_d;
  tx_e          tx_q, tx_d;
  logic [QW-1:0] q_cnt_q, q_cnt_d;
  logic [1:0]   ph_q, ph_d;
  logic [4:0]   bit_cnt_q, bit_cnt_d;
  logic [26:0]  shreg_q, shreg_d;
  logic         tx_nack_q, tx_nack_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [3:0]   tbl_idx_q, tbl_idx_d;
  logic         start_pend_q, start_pend_d;
  logic         scl_q, scl_d, sdao_q, sdao_d;
  logic         nenable_q, nenable_d, nmute_q, nmute_d;
  logic         host_ack_q, host_ack_d, host_nack_q, host_nack_d;
  logic         busy_q, busy_d, done_q, done_d, nack_err_q, nack_err_d;

  logic       qend, fin, ack_slot, launch, enter;
  logic [7:0] l_reg, l_val;

  assign qend     = (q_cnt_q == QW'(CLK_DIV - 1));
  assign fin      = (tx_q == TxStop) && (ph_q == 2'd2) && qend;
  assign ack_slot = (bit_cnt_q == 5'd8) || (bit_cnt_q == 5'd17) || (bit_cnt_q == 5'd26);

  // Top-level sequencing and host arbitration
  always_comb begin
    st_d         = st_q;
    wait_d       = wait_q;
    tbl_idx_d    = tbl_idx_q;
    start_pend_d = start_pend_q;
    nenable_d    = nenable_q;
    done_d       = done_q;
    nack_err_d   = nack_err_q;
    host_ack_d   = 1'b0;
    host_nack_d  = 1'b0;
    launch       = 1'b0;
    enter        = 1'b0;
    l_reg        = tbl_reg;
    l_val        = tbl_val;
    case (st_q)
      StIdle, StErr: if (start) enter = 1'b1;
      StPwrup: begin
        if (wait_q == WW'(PWRUP_CYC - 1)) begin
          st_d   = StInit;
          launch = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StInit: begin
        if (fin) begin
          if (tx_nack_q) begin
            st_d       = StErr;
            nack_err_d = 1'b1;
          end else if (tbl_idx_q == 4'(N_INIT - 1)) begin
            st_d   = StDone;
            done_d = 1'b1;
          end else begin
            tbl_idx_d = tbl_idx_q + 1'b1;
          end
        end else if (tx_q == TxIdle) begin
          launch = 1'b1;
        end
      end
      StDone: begin
        if (fin) begin
          host_ack_d  = 1'b1;
          host_nack_d = tx_nack_q;
          if (start_pend_q || start) enter = 1'b1;
        end else if (tx_q == TxIdle) begin
          if (start) begin
            enter = 1'b1;
          end else if (host_req && !host_ack_q) begin
            // host_ack_q guard keeps a still-high request from relaunching on the ack cycle
            launch = 1'b1;
            l_reg  = host_reg;
            l_val  = host_val;
          end
        end else if (start) begin
          start_pend_d = 1'b1;
        end
      end
      default: st_d = StIdle;
    endcase
    if (enter) begin
      st_d         = StPwrup;
      nenable_d    = 1'b0;
      done_d       = 1'b0;
      nack_err_d   = 1'b0;
      tbl_idx_d    = '0;
      wait_d       = '0;
      start_pend_d = 1'b0;
    end
    nmute_d = done_q & ~mute;
  end

  // I2C write engine; pin values are derived from the next engine state so they are registered
  always_comb begin
    tx_d      = tx_q;
    q_cnt_d   = qend ? '0 : q_cnt_q + 1'b1;
    ph_d      = ph_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    tx_nack_d = tx_nack_q;
    case (tx_q)
      TxIdle: begin
        q_cnt_d = '0;
        if (launch) begin
          tx_d      = TxStart;
          ph_d      = '0;
          bit_cnt_d = '0;
          tx_nack_d = 1'b0;
          shreg_d   = {DEV_ADDR, 1'b0, 1'b1, l_reg, 1'b1, l_val, 1'b1};
        end
      end
      TxStart: begin
        if (qend) begin
          if (ph_q == 2'd1) begin
            tx_d = TxBit;
            ph_d = '0;
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
      end
      TxBit: begin
        if ((ph_q == 2'd3) && (q_cnt_q == '0) && ack_slot && sdai) tx_nack_d = 1'b1;
        if (qend) begin
          ph_d = ph_q + 1'b1;
          if (ph_q == 2'd3) begin
            shreg_d   = {shreg_q[25:0], 1'b1};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if ((bit_cnt_q == 5'd26) || (ack_slot && tx_nack_q)) begin
              tx_d = TxStop;
              ph_d = '0;
            end
          end
        end
      end
      TxStop: begin
        if (qend) begin
          if (ph_q == 2'd2) begin
            tx_d = TxIdle;
            ph_d = '0;
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
      end
      default: tx_d = TxIdle;
    endcase
    case (tx_d)
      TxStart: begin scl_d = 1'b1;      sdao_d = (ph_d == 2'd0); end
      TxBit:   begin scl_d = ph_d[1];   sdao_d = shreg_d[26];    end
      TxStop:  begin scl_d = (ph_d != 2'd0); sdao_d = (ph_d == 2'd2); end
      default: begin scl_d = 1'b1;      sdao_d = 1'b1;           end
    endcase
    busy_d = (tx_d != TxIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= StIdle;
      tx_q         <= TxIdle;
      q_cnt_q      <= '0;
      ph_q         <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '1;
      tx_nack_q    <= 1'b0;
      wait_q       <= '0;
      tbl_idx_q    <= '0;
      start_pend_q <= 1'b0;
      scl_q        <= 1'b1;
      sdao_q       <= 1'b1;
      nenable_q    <= 1'b1;
      nmute_q      <= 1'b0;
      host_ack_q   <= 1'b0;
      host_nack_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      nack_err_q   <= 1'b0;
    end else begin
      st_q         <= st_d;
      tx_q         <= tx_d;
      q_cnt_q      <= q_cnt_d;
      ph_q         <= ph_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      tx_nack_q    <= tx_nack_d;
      wait_q       <= wait_d;
      tbl_idx_q    <= tbl_idx_d;
      start_pend_q <= start_pend_d;
      scl_q        <= scl_d;
      sdao_q       <= sdao_d;
      nenable_q    <= nenable_d;
      nmute_q      <= nmute_d;
      host_ack_q   <= host_ack_d;
      host_nack_q  <= host_nack_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      nack_err_q   <= nack_err_d;
    end
  end

  assign host_ack    = host_ack_q;
  assign host_nack   = host_nack_q;
  assign tbl_idx     = tbl_idx_q;
  assign scl         = scl_q;
  assign sdao        = sdao_q;
  assign amp_nenable = nenable_q;
  assign amp_nmute   = nmute_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign nack_err    = nack_err_q;

endmodule

// File: doc/amp_cfg_seq.md
Name: amp_cfg_seq

Overview:
Power-up and configuration sequencer for the class-D amplifier control interface. After `start` it drives the amplifier enable, waits for power-up, then replays an external init table over a write-only I2C master into the amplifier. It then arbitrates register-bank host writes onto the same I2C bus and releases mute once configuration has succeeded. It sits between the register bank/top level and the amp_i2c_scl/amp_i2c_sda, amp_nenable and amp_nmute pins. Open-drain SDA handling stays at the FPGA/pad level.

Parameters:
- CLK_DIV, 60, clk cycles per SCL quarter-period Q (must be ≥2)
- DEV_ADDR, 7'h20, 7-bit amplifier I2C address
- PWRUP_CYC, 1000, clk cycles from amp_nenable falling to first transaction
- N_INIT, 4, init table entries (1..16)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins the power-up sequence from IDLE, DONE or ERR
- mute  in  1  host mute request
- host_req  in  1  host write request; level, held until host_ack
- host_reg  in  8  host register address
- host_val  in  8  host register value
- host_ack  out  1  one-cycle pulse when the host write completes
- host_nack  out  1  valid with host_ack; 1 = device NACKed
- tbl_idx  out  4  init table index
- tbl_reg  in  8  table register address; combinational function of tbl_idx
- tbl_val  in  8  table register value; combinational function of tbl_idx
- scl  out  1  I2C clock (to amp_i2c_scl)
- sdai  in  1  SDA input
- sdao  out  1  SDA drive; 0 = pull low, 1 = release
- amp_nenable  out  1  amplifier enable, active-low
- amp_nmute  out  1  amplifier mute, active-low
- busy  out  1  a transaction is in progress
- done  out  1  init completed with no NACK
- nack_err  out  1  sticky; init sequence aborted on NACK

Behaviour:
- Reset values:
  - state IDLE
  - scl=1, sdao=1
  - amp_nenable=1, amp_nmute=0
  - host_ack=0, host_nack=0
  - tbl_idx=0, busy=0, done=0, nack_err=0
- Reset mid-transaction aborts immediately and releases both lines; no STOP is generated.
- Top FSM states: IDLE, PWRUP, INIT, DONE, ERR.
  - IDLE/DONE/ERR + start → PWRUP. On entry: amp_nenable=0, done=0, nack_err=0, tbl_idx=0, wait counter cleared.
  - PWRUP: after PWRUP_CYC cycles → INIT.
  - INIT: issues one write per entry {tbl_reg, tbl_val}.
    - ACK: tbl_idx+1.
    - After entry N_INIT-1 ACKs → DONE with done=1.
    - Any NACK → ERR with nack_err=1 and tbl_idx frozen at the failing entry.
  - In ERR: amp_nenable stays 0; amp_nmute stays 0.
- amp_nmute = done & ~mute, registered (one-cycle lag).
- Arbitration:
  - host_req is serviced only in DONE and only when no transaction is active. The request is latched when the transaction launches.
  - host_req outside DONE is held pending; it is neither acknowledged nor dropped. It is serviced after DONE is reached, and never in ERR.
  - start in DONE while a host transaction is active: the transaction finishes, host_ack pulses, then PWRUP is entered.
  - start during PWRUP/INIT is ignored.
- I2C write transaction, Q=CLK_DIV cycles:
  - START (2Q): scl=1 throughout; sdao=1 for Q, then sdao=0 for Q.
  - 27 bits: {DEV_ADDR,0}, ACK, reg, ACK, val, ACK; MSB first. Each bit is 4Q:
    - phases 0–1: scl=0, sdao=bit, released during ACK slots
    - phases 2–3: scl=1
  - sdai is sampled on the first cycle of phase 3. ACK = sdai==0.
  - STOP (3Q): scl=0/sdao=0 for Q; scl=1/sdao=0 for Q; scl=1/sdao=1 for Q.
  - On NACK, the remaining bytes are skipped and STOP is issued right after the ACK bit.
  - Full transaction = 113Q cycles. busy=1 from the first START cycle through the last STOP cycle.
  - host_ack and host_nack are asserted on the cycle after the STOP ends.
- No clock stretching; no arbitration loss; no reads.

Test Plan:
- CLK_DIV=4, PWRUP_CYC=10, N_INIT=2, table {0x35→0x08, 0x36→0x10}, slave always ACKs; start → amp_nenable falls next cycle; first SDA fall 10+Q cycles later; bytes 0x40,0x35,0x08 then 0x40,0x36,0x10; each transaction 452 cycles; done=1; amp_nmute=1 one cycle later.
- Slave NACKs the data byte of entry 1 → STOP follows that ACK slot; nack_err=1, done=0, tbl_idx=1, amp_nmute=0; host_req=1 stays unacknowledged.
- In DONE, host_req {0x10, 0xAA} with ACK → bytes 0x40,0x10,0xAA; host_ack pulse one cycle, host_nack=0, busy low on that cycle.
- host_req asserted during PWRUP → serviced immediately after the last init STOP, exactly once.
- Set mute=1 in DONE → amp_nmute=0 after one cycle; clear mute → amp_nmute=1.
- reset mid-byte (e.g. bit 12) → next cycle scl=1, sdao=1, amp_nenable=1, state IDLE; a subsequent start reruns the full sequence correctly.
